// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, widths and helpers for the register-slave slice.
package axi_lite_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Register index width; a single-register bank still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Replace only the bytes whose strobe is set.
    function automatic logic [AXI_DATA_W-1:0] strb_merge(
        input logic [AXI_DATA_W-1:0] old_val,
        input logic [AXI_DATA_W-1:0] new_val,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(AXI_STRB_W); i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Word-address decoder for the register bank; byte offset bits are ignored.
// AXI_SLV_ID_REG_EN adds a read-only ID word just past the last register.
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned IDX_W    = idx_width(NUM_REGS)
) (
    input  logic [AXI_ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]      index,
    output logic                  in_range,
    output logic                  is_id_reg
);

    logic [AXI_ADDR_W-3:0] word;
    logic                  unused_bits;

    assign word        = addr[AXI_ADDR_W-1:2];
    assign unused_bits = ^addr[1:0];
    assign index       = addr[2 +: IDX_W];
    assign in_range    = (word < (AXI_ADDR_W-2)'(NUM_REGS));

`ifdef AXI_SLV_ID_REG_EN
    assign is_id_reg = (word == (AXI_ADDR_W-2)'(NUM_REGS));
`else
    assign is_id_reg = 1'b0;
`endif

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave backed by NUM_REGS 32-bit RW registers, one outstanding
// write and one outstanding read. Optional ID register: AXI_SLV_ID_REG_EN.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 8,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'hA11E_0001
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [AXI_ADDR_W-1:0]    awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [AXI_DATA_W-1:0]    wdata,
    input  logic [AXI_STRB_W-1:0]    wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [AXI_ADDR_W-1:0]    araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [AXI_DATA_W-1:0]    rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [NUM_REGS*32-1:0]   reg_q
);

    localparam int unsigned IDX_W = idx_width(NUM_REGS);

    logic [AXI_DATA_W-1:0] regs [NUM_REGS];

    w_state_e              w_state, w_state_n;
    logic                  aw_held, aw_held_n, w_held, w_held_n;
    logic                  awready_q, awready_n, wready_q, wready_n;
    logic                  bvalid_q, bvalid_n;
    resp_t                 bresp_q, bresp_n;
    logic [AXI_ADDR_W-1:0] awaddr_q;
    logic [AXI_DATA_W-1:0] wdata_q;
    logic [AXI_STRB_W-1:0] wstrb_q;
    logic                  aw_hs, w_hs, aw_have, w_have, wr_en;

    r_state_e              r_state, r_state_n;
    logic                  arready_q, arready_n, rvalid_q, rvalid_n;
    resp_t                 rresp_q, rresp_n;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_n;
    logic                  ar_hs;

    logic [AXI_ADDR_W-1:0] wr_addr;
    logic [AXI_DATA_W-1:0] wr_data;
    logic [AXI_STRB_W-1:0] wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_in_range, wr_is_id, rd_in_range, rd_is_id;

    assign aw_hs   = awvalid && awready_q;
    assign w_hs    = wvalid && wready_q;
    assign aw_have = aw_held || aw_hs;
    assign w_have  = w_held || w_hs;
    assign ar_hs   = arvalid && arready_q;

    // A beat captured on an earlier edge comes from the holding registers.
    assign wr_addr = aw_held ? awaddr_q : awaddr;
    assign wr_data = w_held ? wdata_q : wdata;
    assign wr_strb = w_held ? wstrb_q : wstrb;

    axi_lite_addr_decode #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_wr_dec (
        .addr      (wr_addr),
        .index     (wr_idx),
        .in_range  (wr_in_range),
        .is_id_reg (wr_is_id)
    );

    axi_lite_addr_decode #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rd_dec (
        .addr      (araddr),
        .index     (rd_idx),
        .in_range  (rd_in_range),
        .is_id_reg (rd_is_id)
    );

    // Write channel next-state and outputs
    always_comb begin
        w_state_n = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        wr_en     = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_have && w_have) begin
                    wr_en     = wr_in_range;
                    bvalid_n  = 1'b1;
                    bresp_n   = wr_in_range ? OKAY : (wr_is_id ? SLVERR : DECERR);
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                    w_state_n = W_RESP;
                end else begin
                    aw_held_n = aw_have;
                    w_held_n  = w_have;
                    awready_n = !aw_have;
                    wready_n  = !w_have;
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // Read channel next-state and outputs; regs are sampled before any same-edge write
    always_comb begin
        r_state_n = r_state;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rresp_n   = rresp_q;
        rdata_n   = rdata_q;
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (ar_hs) begin
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rdata_n   = rd_in_range ? regs[rd_idx] : (rd_is_id ? ID_VALUE : '0);
                    rresp_n   = (rd_in_range || rd_is_id) ? OKAY : DECERR;
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            w_state   <= w_state_n;
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
            r_state   <= r_state_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rresp_q   <= rresp_n;
            rdata_q   <= rdata_n;
        end
    end

    // Holding registers for a beat that arrives before its partner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_hs) awaddr_q <= awaddr;
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NUM_REGS); k++) regs[k] <= RESET_VAL;
        end else if (wr_en) begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                if (wr_idx == IDX_W'(k)) regs[k] <= strb_merge(regs[k], wr_data, wr_strb);
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_reg_q
        assign reg_q[32*k +: 32] = regs[k];
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed self-checking bench for axi_lite_slave_regs (NUM_REGS=8).
// Honours AXI_SLV_ID_REG_EN when the DUT is built with it.
module tb_axi_lite_slave_regs;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;
    logic [255:0] reg_q;

    int total = 0;
    int bad   = 0;

    axi_lite_slave_regs dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .reg_q   (reg_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rq(input int k);
        return reg_q[32*k +: 32];
    endfunction

    // Called on a negedge; returns on a negedge with the response accepted.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int n);
        logic aw_go, w_go;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin
            aw_go = awready;
            w_go  = wready;
            @(negedge clk);
            n++;
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
        end
        chk("wr_timeout", 64'(n < 20), 64'd1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output int n);
        logic ar_go;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin
            ar_go = arready;
            @(negedge clk);
            n++;
            if (ar_go) arvalid = 1'b0;
        end
        chk("rd_timeout", 64'(n < 20), 64'd1);
        d = rdata;
        resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        int          n;

        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'({awready, wready, arready}), 64'b000);
        chk("rst_valid", 64'({bvalid, bresp, rvalid, rresp}), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_regs", 64'(reg_q == '0), 64'd1);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", 64'({awready, wready, arready}), 64'b000);
        @(negedge clk);
        chk("post_rst_ready", 64'({awready, wready, arready}), 64'b111);

        // Simultaneous AW+W, full strobe
        axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, resp, n);
        chk("wr1_resp", 64'(resp), 64'b00);
        chk("wr1_lat", 64'(n), 64'd1);
        chk("wr1_reg1", 64'(rq(1)), 64'hDEAD_BEEF);
        chk("wr1_idle_ready", 64'({awready, wready, bvalid}), 64'b110);
        axi_read(32'h04, d, resp, n);
        chk("rd1_data", 64'(d), 64'hDEAD_BEEF);
        chk("rd1_resp", 64'(resp), 64'b00);
        chk("rd1_lat", 64'(n), 64'd1);
        chk("rd1_idle", 64'({arready, rvalid}), 64'b10);
        axi_read(32'h07, d, resp, n);
        chk("rd_lowbits", 64'(d), 64'hDEAD_BEEF);

        // W three cycles ahead of AW
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        chk("wfirst_wready", 64'({wready, awready, bvalid}), 64'b010);
        repeat (2) @(negedge clk);
        chk("wfirst_wait", 64'({wready, awready, bvalid}), 64'b010);
        chk("wfirst_noupd", 64'(rq(2)), 64'd0);
        awaddr = 32'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("wfirst_b", 64'({bvalid, bresp}), 64'b100);
        chk("wfirst_reg2", 64'(rq(2)), 64'h1234_5678);
        @(negedge clk);
        bready = 1'b0;
        chk("wfirst_done", 64'({bvalid, awready, wready}), 64'b011);

        // Byte strobes
        axi_write(32'h00, 32'h1122_3344, 4'hF, resp, n);
        axi_write(32'h00, 32'hAABB_CCDD, 4'b0101, resp, n);
        chk("strb_resp", 64'(resp), 64'b00);
        chk("strb_reg0", 64'(rq(0)), 64'h11BB_33DD);
        axi_write(32'h00, 32'hFFFF_FFFF, 4'h0, resp, n);
        chk("strb0_resp", 64'(resp), 64'b00);
        chk("strb0_reg0", 64'(rq(0)), 64'h11BB_33DD);

        // Out of range, and the word just past the bank
        axi_write(32'h40, 32'h5555_5555, 4'hF, resp, n);
        chk("oor_bresp", 64'(resp), 64'b11);
        chk("oor_reg0", 64'(rq(0)), 64'h11BB_33DD);
        chk("oor_regs", 64'(reg_q[255:96] == '0), 64'd1);
        axi_read(32'h40, d, resp, n);
        chk("oor_rresp", 64'(resp), 64'b11);
        chk("oor_rdata", 64'(d), 64'd0);
        axi_write(32'h20, 32'h6666_6666, 4'hF, resp, n);
`ifdef AXI_SLV_ID_REG_EN
        chk("id_bresp", 64'(resp), 64'b10);
`else
        chk("id_bresp", 64'(resp), 64'b11);
`endif
        chk("id_reg0", 64'(rq(0)), 64'h11BB_33DD);
        axi_read(32'h20, d, resp, n);
`ifdef AXI_SLV_ID_REG_EN
        chk("id_rdata", 64'(d), 64'hA11E_0001);
        chk("id_rresp", 64'(resp), 64'b00);
`else
        chk("id_rdata", 64'(d), 64'd0);
        chk("id_rresp", 64'(resp), 64'b11);
`endif

        // Back-pressure plus same-edge read/write of reg3
        awaddr = 32'h0C; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h0C; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("bp_reg3", 64'(rq(3)), 64'hCAFE_F00D);
        for (int i = 0; i < 4; i++) begin
            chk("bp_b", 64'({bvalid, bresp, awready, wready}), 64'b10000);
            chk("bp_r", 64'({rvalid, rresp, arready, rdata}), {29'd0, 1'b1, 2'b00, 1'b0, 32'h0});
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("bp_r_done", 64'({rvalid, arready}), 64'b01);
        chk("bp_b_still", 64'({bvalid, awready, wready}), 64'b100);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bp_b_done", 64'({bvalid, awready, wready}), 64'b011);
        axi_read(32'h0C, d, resp, n);
        chk("bp_rd3", 64'(d), 64'hCAFE_F00D);

        // Reset while a write response is pending
        awaddr = 32'h10; awvalid = 1'b1; wdata = 32'h0BAD_0BAD; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("rst2_pending", 64'(bvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst2_out", 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp}), 64'd0);
        chk("rst2_regs", 64'(reg_q == '0), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst2_rel", 64'({awready, wready, arready}), 64'b000);
        @(negedge clk);
        chk("rst2_ready", 64'({awready, wready, arready, bvalid}), 64'b1110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
